debouncer: RTL and testbench
============================

DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_MHZ, default 150, giving the clock frequency in MHz.
REQ-002 The block SHALL have parameter GLITCH_TIME_NS, default 100, giving the minimum stable-press time in ns.
REQ-003 The block SHALL derive localparam GLITCH_CYCLES = max(1, GLITCH_TIME_NS*CLK_FREQ_MHZ/1000) using integer division (15 at defaults).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port key_i, input, 1 bit: raw, asynchronous, bouncing key level; 1 = pressed.
REQ-007 The block SHALL have port key_pressed_stb_o, output, 1 bit: one-cycle strobe marking a debounced press.
REQ-008 The block SHALL use one clock and one asynchronous active-high reset, with no other clocks or resets.

Function
REQ-009 The block SHALL pass key_i through a 2-flop synchronizer (s1, s2) before any other use.
REQ-010 The block SHALL keep a stability counter, width $clog2(GLITCH_CYCLES+1), that increments each cycle s2=1 and saturates at GLITCH_CYCLES.
REQ-011 The counter SHALL clear to 0 in any cycle s2=0, so a single low sample aborts the press.
REQ-012 key_pressed_stb_o SHALL be a registered output and SHALL go high for exactly one cycle when the counter reaches GLITCH_CYCLES.
REQ-013 Latency: if key_i is high at rising edges 0..GLITCH_CYCLES+1, key_pressed_stb_o SHALL be high in the cycle after edge GLITCH_CYCLES+1 (the (GLITCH_CYCLES+2)th high edge).
REQ-014 Latency: the strobe SHALL NOT occur earlier than the time in REQ-013.
REQ-015 A held key SHALL produce only one strobe: a "fired" flag sets on the strobe and blocks further strobes while s2=1.
REQ-016 The fired flag SHALL clear when s2=0, re-arming the block for the next press.
REQ-017 Fewer than GLITCH_CYCLES consecutive synchronized high samples SHALL produce no strobe.
REQ-018 Releasing the key SHALL never produce a strobe.
REQ-019 key_i changing on the same edge as a strobe SHALL NOT affect that strobe; the strobe still lasts exactly one cycle.

Reset
REQ-020 While rst_i=1, s1, s2, the counter, the fired flag and key_pressed_stb_o SHALL be 0, taking effect immediately and asynchronously to clk_i.
REQ-021 Reset asserted mid-count or mid-strobe SHALL abort the count or strobe.
REQ-022 After reset release, a press SHALL again need the full latency of REQ-013 from the first high sample after release.

Verification
REQ-023 Steady press: defaults, key_i=1 continuously from edge 0 -> single strobe in the cycle after edge 16, then no more strobes for 100 cycles.
REQ-024 Glitchy press: key_i high 10 cycles, low 1 cycle, high 30 cycles -> no strobe in the first segment; one strobe 17 edges after the second rise.
REQ-025 Short pulses: key_i high for 14 cycles, then low, repeated 20 times -> no strobe at any time.
REQ-026 Re-press: key_i high 20 cycles, low 3 cycles, high 20 cycles -> exactly two strobes, each 17 edges after its rise.
REQ-027 Reset mid-count: key_i=1, rst_i pulsed at edge 10 -> output 0 immediately on assertion; strobe 17 edges after reset release.
REQ-028 Random stress: 1000 cycles with key_i=1 at 97% probability -> a strobe only when the count of consecutive high samples equals GLITCH_CYCLES+2, never otherwise, and at most one strobe per high run.

Source files
------------

// File: rtl/debouncer.sv
// Key debouncer. A raw key level is synchronised and must be seen high for
// GLITCH_CYCLES consecutive synchronised samples before a single one-cycle
// press strobe is emitted. Any low sample aborts the count and re-arms.
module debouncer #(
   parameter int unsigned CLK_FREQ_MHZ   = 150,
   parameter int unsigned GLITCH_TIME_NS = 100
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_i,
   output logic key_pressed_stb_o
);

   localparam int unsigned GLITCH_RAW    = (GLITCH_TIME_NS * CLK_FREQ_MHZ) / 1000;
   localparam int unsigned GLITCH_CYCLES = (GLITCH_RAW < 1) ? 1 : GLITCH_RAW;
   localparam int unsigned CW            = $clog2(GLITCH_CYCLES + 1);
   localparam logic [CW-1:0] C_MAX       = CW'(GLITCH_CYCLES);

   logic          r_s1;
   logic          r_s2;
   logic [CW-1:0] r_cnt;
   logic          r_fired;
   logic          r_stb;
   logic [CW-1:0] w_cnt_next;
   logic          w_fire;

   // Two-flop synchroniser for the asynchronous key level
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= key_i;
         r_s2 <= r_s1;
      end
   end

   // Next stability count: clear on a low sample, count up and saturate on high.
   // The strobe is decided from this next value so it registers on the same
   // edge the count reaches GLITCH_CYCLES.
   always_comb begin
      w_cnt_next = '0;
      w_fire     = 1'b0;
      if (r_s2) begin
         if (r_cnt == C_MAX) begin
            w_cnt_next = r_cnt;
         end else begin
            w_cnt_next = r_cnt + CW'(1);
         end
         w_fire = (w_cnt_next == C_MAX) && !r_fired;
      end
   end

   // Stability counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   // Registered strobe plus fired flag that blocks repeats while the key is held
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stb   <= 1'b0;
         r_fired <= 1'b0;
      end else begin
         r_stb <= w_fire;
         if (!r_s2) begin
            r_fired <= 1'b0;
         end else if (w_fire) begin
            r_fired <= 1'b1;
         end
      end
   end

   assign key_pressed_stb_o = r_stb;

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for the key debouncer at default parameters (15 stable cycles,
// strobe visible after the 17th consecutive high edge).
module tb_debouncer;

   localparam int unsigned G = 15;

   logic clk_i = 1'b0;
   logic rst_i;
   logic key_i;
   logic key_pressed_stb_o;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   debouncer #(
      .CLK_FREQ_MHZ  (150),
      .GLITCH_TIME_NS(100)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .key_i            (key_i),
      .key_pressed_stb_o(key_pressed_stb_o)
   );

   // Apply key for one edge, sample the strobe 1 time unit later
   task automatic step(input logic k, output logic stb);
      key_i = k;
      @(posedge clk_i);
      #1;
      stb = key_pressed_stb_o;
   endtask

   task automatic idle(input int n);
      logic s;
      for (int i = 0; i < n; i++) step(1'b0, s);
   endtask

   task automatic test_reset;
      logic s;
      rst_i = 1'b1;
      key_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i);
         #1;
         s = key_pressed_stb_o;
         vectors++;
         if (s !== 1'b0) begin
            miscompares++;
            $display("FAIL reset cycle %0d: strobe=%b expected 0", i, s);
         end
      end
      rst_i = 1'b0;
      idle(4);
   endtask

   task automatic test_steady;
      logic s;
      logic exp;
      for (int i = 0; i < 117; i++) begin
         step(1'b1, s);
         exp = (i == 16);
         vectors++;
         if (s !== exp) begin
            miscompares++;
            $display("FAIL steady step %0d: strobe=%b expected %b", i, s, exp);
         end
      end
      idle(4);
   endtask

   task automatic test_glitchy;
      logic s;
      logic k;
      logic exp;
      for (int i = 0; i < 46; i++) begin
         k   = (i < 10) || (i >= 11 && i < 41);
         step(k, s);
         exp = (i == 27);
         vectors++;
         if (s !== exp) begin
            miscompares++;
            $display("FAIL glitchy step %0d: strobe=%b expected %b", i, s, exp);
         end
      end
      idle(2);
   endtask

   // Exactly GLITCH_CYCLES high samples: strobe fires even though the key
   // has already dropped on the strobe edge, and lasts one cycle
   task automatic test_exact_boundary;
      logic s;
      logic exp;
      for (int i = 0; i < 24; i++) begin
         step(i < G, s);
         exp = (i == 16);
         vectors++;
         if (s !== exp) begin
            miscompares++;
            $display("FAIL boundary step %0d: strobe=%b expected %b", i, s, exp);
         end
      end
   endtask

   task automatic test_short_pulses;
      logic s;
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 15; i++) begin
            step(i < 14, s);
            vectors++;
            if (s !== 1'b0) begin
               miscompares++;
               $display("FAIL short rep %0d step %0d: strobe=%b expected 0", r, i, s);
            end
         end
      end
      idle(3);
   endtask

   task automatic test_back_to_back;
      logic s;
      logic k;
      logic exp;
      for (int i = 0; i < 48; i++) begin
         k   = (i < 20) || (i >= 23 && i < 43);
         step(k, s);
         exp = (i == 16) || (i == 39);
         vectors++;
         if (s !== exp) begin
            miscompares++;
            $display("FAIL repress step %0d: strobe=%b expected %b", i, s, exp);
         end
      end
   endtask

   task automatic test_reset_mid_count;
      logic s;
      logic exp;
      for (int i = 0; i < 10; i++) step(1'b1, s);
      rst_i = 1'b1;
      #1;
      vectors++;
      if (key_pressed_stb_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_count_assert: strobe=%b expected 0", key_pressed_stb_o);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      for (int i = 0; i < 22; i++) begin
         step(1'b1, s);
         exp = (i == 16);
         vectors++;
         if (s !== exp) begin
            miscompares++;
            $display("FAIL rst_count step %0d: strobe=%b expected %b", i, s, exp);
         end
      end
      idle(4);
   endtask

   task automatic test_reset_mid_strobe;
      logic s;
      logic exp;
      for (int i = 0; i < 17; i++) step(1'b1, s);
      vectors++;
      if (s !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_strobe_pre: strobe=%b expected 1", s);
      end
      rst_i = 1'b1;
      #1;
      vectors++;
      if (key_pressed_stb_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_strobe_async: strobe=%b expected 0", key_pressed_stb_o);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      for (int i = 0; i < 22; i++) begin
         step(1'b1, s);
         exp = (i == 16);
         vectors++;
         if (s !== exp) begin
            miscompares++;
            $display("FAIL rst_strobe step %0d: strobe=%b expected %b", i, s, exp);
         end
      end
      idle(4);
   endtask

   // Random key with rare drops; reference tracks the run of high samples two
   // edges back and expects a strobe when that run length first equals G
   task automatic test_random_stress;
      logic s;
      logic k;
      logic exp;
      logic d1;
      logic d2;
      int   run;
      int   strobes;
      d1      = 1'b0;
      d2      = 1'b0;
      run     = 0;
      strobes = 0;
      for (int i = 0; i < 1000; i++) begin
         k   = ($urandom_range(99) < 97);
         run = d2 ? ((run < 100000) ? run + 1 : run) : 0;
         exp = (run == G);
         d2  = d1;
         d1  = k;
         step(k, s);
         if (s === 1'b1) strobes++;
         vectors++;
         if (s !== exp) begin
            miscompares++;
            $display("FAIL stress step %0d: strobe=%b expected %b (run=%0d)", i, s, exp, run);
         end
      end
      idle(4);
   endtask

   initial begin
      rst_i = 1'b1;
      key_i = 1'b0;
      test_reset;
      test_steady;
      test_glitchy;
      test_exact_boundary;
      test_short_pulses;
      test_back_to_back;
      test_reset_mid_count;
      test_reset_mid_strobe;
      test_random_stress;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
